// File: rtl/clk_div_pkg.sv
// Shared definitions for the divider ratio controller: FSM state codes,
// default divider parameters and a small sizing helper.
package clk_div_pkg;

    // FSM state codes (2-bit encoding)
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_DRAIN  = 2'd1;
    localparam logic [1:0] ST_HOLD   = 2'd2;
    localparam logic [1:0] ST_SETTLE = 2'd3;

    // Default configuration of the divider controller
    localparam int WIDTH_DEF         = 4;
    localparam int N_DEFAULT_DEF     = 3;
    localparam int N_MIN_DEF         = 2;
    localparam int SETTLE_CYCLES_DEF = 2;

    // Larger of two integers, used to size the shared down-counter
    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/clk_div_wdog.sv
// Loadable down-counter with a zero flag. The controller uses it both as the
// DRAIN watchdog and as the SETTLE cycle counter. The count stops at zero so
// it never wraps.
module clk_div_wdog #(
    parameter int CW = 5
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          load,
    input  logic [CW-1:0] load_val,
    input  logic          dec,
    output logic          cnt_zero
);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Next count: a load wins over a decrement; the count holds at zero
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (dec && (cnt_q != {CW{1'b0}})) begin
            cnt_d = cnt_q - {{(CW-1){1'b0}}, 1'b1};
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= {CW{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_zero = (cnt_q == {CW{1'b0}});

endmodule

// File: rtl/clk_div_ratio_ctrl.sv
// Run-time divisor controller for the core clock divider. It accepts a new
// divisor and waits for a divider period boundary. It then gates the divided
// clock, holds the divider in reset for one cycle while loading the new N, and
// lets the divider settle before ungating.
// Optional feature: define CLK_DIV_CTRL_STATS_EN to add the change_cnt and
// wdog_hit status outputs.
module clk_div_ratio_ctrl
    import clk_div_pkg::*;
#(
    parameter int WIDTH         = WIDTH_DEF,
    parameter int N_DEFAULT     = N_DEFAULT_DEF,
    parameter int N_MIN         = N_MIN_DEF,
    parameter int SETTLE_CYCLES = SETTLE_CYCLES_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    input  logic [WIDTH-1:0] req_n,
    output logic             req_ready,
    output logic             req_err,
    input  logic             div_wrap,
    output logic [WIDTH-1:0] div_n,
    output logic             div_reset,
    output logic             clk_gate_en,
    output logic             busy
`ifdef CLK_DIV_CTRL_STATS_EN
    ,
    output logic [15:0]      change_cnt,
    output logic             wdog_hit
`endif
);

    localparam int WD_W  = $clog2((2**WIDTH) + 1);
    localparam int ST_W  = $clog2(SETTLE_CYCLES + 1);
    localparam int CNT_W = max_int(WD_W, ST_W);

    // The DRAIN watchdog gives 2^WIDTH cycles (counts 2^WIDTH-1 down to 0)
    localparam logic [CNT_W-1:0] WDOG_LOAD   = CNT_W'((2**WIDTH) - 1);
    localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [WIDTH-1:0] N_DEF_V     = WIDTH'(N_DEFAULT);
    localparam logic [WIDTH-1:0] N_MIN_V     = WIDTH'(N_MIN);

    logic [1:0]       state_q,       state_d;
    logic [WIDTH-1:0] pending_q,     pending_d;
    logic [WIDTH-1:0] div_n_q,       div_n_d;
    logic             div_reset_q,   div_reset_d;
    logic             clk_gate_en_q, clk_gate_en_d;
    logic             req_ready_q,   req_ready_d;
    logic             req_err_q,     req_err_d;
    logic             busy_q,        busy_d;

    logic             accept_s;
    logic             change_s;
    logic             cnt_load_s;
    logic [CNT_W-1:0] cnt_load_val_s;
    logic             cnt_dec_s;
    logic             cnt_zero_s;

    clk_div_wdog #(
        .CW (CNT_W)
    ) u_wdog (
        .clk      (clk),
        .reset    (reset),
        .load     (cnt_load_s),
        .load_val (cnt_load_val_s),
        .dec      (cnt_dec_s),
        .cnt_zero (cnt_zero_s)
    );

    // FSM next-state, pending divisor, error pulse and counter control
    always_comb begin
        accept_s       = req_valid & req_ready_q;
        state_d        = state_q;
        pending_d      = pending_q;
        req_err_d      = 1'b0;
        change_s       = 1'b0;
        cnt_load_s     = 1'b0;
        cnt_load_val_s = {CNT_W{1'b0}};
        cnt_dec_s      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    if (req_n < N_MIN_V) begin
                        req_err_d = 1'b1;
                    end else if (req_n == div_n_q) begin
                        // Same divisor: nothing to change, keep running ungated
                        state_d = ST_IDLE;
                    end else begin
                        pending_d      = req_n;
                        state_d        = ST_DRAIN;
                        cnt_load_s     = 1'b1;
                        cnt_load_val_s = WDOG_LOAD;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_DRAIN: begin
                if (div_wrap) begin
                    state_d  = ST_HOLD;
                    change_s = 1'b1;
                end else if (cnt_zero_s) begin
                    // Divider never reported a boundary: switch anyway
                    state_d  = ST_HOLD;
                    change_s = 1'b1;
                end else begin
                    cnt_dec_s = 1'b1;
                end
            end
            ST_HOLD: begin
                state_d        = ST_SETTLE;
                cnt_load_s     = 1'b1;
                cnt_load_val_s = SETTLE_LOAD;
            end
            ST_SETTLE: begin
                if (cnt_zero_s) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_dec_s = 1'b1;
                end
            end
            default: begin
                state_d = ST_HOLD;
            end
        endcase
    end

    // Output decode from the next state so every output leaves a flop.
    // The gate stays open through DRAIN and closes together with HOLD entry.
    always_comb begin
        div_n_d       = change_s ? pending_q : div_n_q;
        div_reset_d   = (state_d == ST_HOLD);
        clk_gate_en_d = (state_d == ST_IDLE) || (state_d == ST_DRAIN);
        req_ready_d   = (state_d == ST_IDLE);
        busy_d        = (state_d != ST_IDLE);
    end

    // Controller state and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_HOLD;
            pending_q     <= N_DEF_V;
            div_n_q       <= N_DEF_V;
            div_reset_q   <= 1'b1;
            clk_gate_en_q <= 1'b0;
            req_ready_q   <= 1'b0;
            req_err_q     <= 1'b0;
            busy_q        <= 1'b1;
        end else begin
            state_q       <= state_d;
            pending_q     <= pending_d;
            div_n_q       <= div_n_d;
            div_reset_q   <= div_reset_d;
            clk_gate_en_q <= clk_gate_en_d;
            req_ready_q   <= req_ready_d;
            req_err_q     <= req_err_d;
            busy_q        <= busy_d;
        end
    end

    assign req_ready   = req_ready_q;
    assign req_err     = req_err_q;
    assign div_n       = div_n_q;
    assign div_reset   = div_reset_q;
    assign clk_gate_en = clk_gate_en_q;
    assign busy        = busy_q;

`ifdef CLK_DIV_CTRL_STATS_EN
    logic [15:0] change_cnt_q, change_cnt_d;
    logic        wdog_hit_q,   wdog_hit_d;
    logic        wdog_exp_s;

    // Saturating count of request-driven divisor changes; sticky watchdog flag
    always_comb begin
        wdog_exp_s   = (state_q == ST_DRAIN) && !div_wrap && cnt_zero_s;
        change_cnt_d = change_cnt_q;
        if (change_s && (change_cnt_q != 16'hFFFF)) begin
            change_cnt_d = change_cnt_q + 16'd1;
        end else begin
            change_cnt_d = change_cnt_q;
        end
        wdog_hit_d = wdog_hit_q | wdog_exp_s;
    end

    // Statistics registers
    always_ff @(posedge clk) begin
        if (reset) begin
            change_cnt_q <= 16'd0;
            wdog_hit_q   <= 1'b0;
        end else begin
            change_cnt_q <= change_cnt_d;
            wdog_hit_q   <= wdog_hit_d;
        end
    end

    assign change_cnt = change_cnt_q;
    assign wdog_hit   = wdog_hit_q;
`endif

endmodule

// File: tb/tb_clk_div_ratio_ctrl.sv
// Self-checking bench for clk_div_ratio_ctrl. The reference model tracks the
// active divisor and predicts the length of each change sequence from the
// wrap delay: min(delay, 16) drain cycles + 1 hold + SETTLE settle cycles.
module tb_clk_div_ratio_ctrl;

    localparam int N_DEF  = 3;
    localparam int N_MIN  = 2;
    localparam int SETTLE = 2;
    localparam int WDOG   = 16;

    logic       clk = 1'b0;
    logic       reset;
    logic       req_valid;
    logic [3:0] req_n;
    logic       req_ready;
    logic       req_err;
    logic       div_wrap;
    logic [3:0] div_n;
    logic       div_reset;
    logic       clk_gate_en;
    logic       busy;
`ifdef CLK_DIV_CTRL_STATS_EN
    logic [15:0] change_cnt;
    logic        wdog_hit;
`endif

    int n_vec = 0;
    int n_err = 0;
    int model_n;

    always #5 clk = ~clk;

    clk_div_ratio_ctrl dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_n       (req_n),
        .req_ready   (req_ready),
        .req_err     (req_err),
        .div_wrap    (div_wrap),
        .div_n       (div_n),
        .div_reset   (div_reset),
        .clk_gate_en (clk_gate_en),
        .busy        (busy)
`ifdef CLK_DIV_CTRL_STATS_EN
        ,
        .change_cnt  (change_cnt),
        .wdog_hit    (wdog_hit)
`endif
    );

    // Reset, then follow HOLD -> SETTLE -> IDLE sample by sample
    task automatic test_reset();
        logic exp_rst, exp_gate;
        @(negedge clk);
        reset = 1'b1; req_valid = 1'b0; div_wrap = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        model_n = N_DEF;
        for (int k = 0; k <= SETTLE + 1; k++) begin
            exp_rst  = (k == 0);
            exp_gate = (k == SETTLE + 1);
            n_vec++;
            if (div_reset !== exp_rst) begin
                n_err++; $display("FAIL reset_div_reset k=%0d got %b exp %b", k, div_reset, exp_rst);
            end
            n_vec++;
            if (clk_gate_en !== exp_gate) begin
                n_err++; $display("FAIL reset_gate k=%0d got %b exp %b", k, clk_gate_en, exp_gate);
            end
            n_vec++;
            if (busy !== !exp_gate) begin
                n_err++; $display("FAIL reset_busy k=%0d got %b exp %b", k, busy, !exp_gate);
            end
            n_vec++;
            if (req_err !== 1'b0) begin
                n_err++; $display("FAIL reset_req_err k=%0d got %b exp 0", k, req_err);
            end
            if (k < SETTLE + 1) @(negedge clk);
        end
        n_vec++;
        if (div_n !== 4'(model_n)) begin
            n_err++; $display("FAIL reset_div_n got %0d exp %0d", div_n, model_n);
        end
        n_vec++;
        if (req_ready !== 1'b1) begin
            n_err++; $display("FAIL reset_ready got %b exp 1", req_ready);
        end
    endtask

    // One request; d = drain cycle in which div_wrap pulses, inject = poke a
    // second request while busy (it must be ignored)
    task automatic send_req(input int n, input int d, input bit inject);
        int s, busy_c, gate_lo, rst_hi, exp_drain;
        n_vec++;
        if (req_ready !== 1'b1) begin
            n_err++; $display("FAIL req_ready_idle got %b exp 1", req_ready);
        end
        req_valid = 1'b1; req_n = 4'(n); div_wrap = 1'b0;
        @(negedge clk);
        req_valid = 1'b0;
        if (n < N_MIN) begin
            n_vec++;
            if (req_err !== 1'b1 || busy !== 1'b0) begin
                n_err++; $display("FAIL illegal_req err=%b busy=%b exp err=1 busy=0", req_err, busy);
            end
            n_vec++;
            if (div_n !== 4'(model_n)) begin
                n_err++; $display("FAIL illegal_div_n got %0d exp %0d", div_n, model_n);
            end
            @(negedge clk);
            n_vec++;
            if (req_err !== 1'b0) begin
                n_err++; $display("FAIL err_pulse_width got %b exp 0", req_err);
            end
        end else if (n == model_n) begin
            n_vec++;
            if (busy !== 1'b0 || clk_gate_en !== 1'b1 || req_err !== 1'b0) begin
                n_err++; $display("FAIL noop_req busy=%b gate=%b err=%b exp 0 1 0", busy, clk_gate_en, req_err);
            end
        end else begin
            exp_drain = (d < WDOG) ? d : WDOG;
            busy_c = 0; gate_lo = 0; rst_hi = 0; s = 1;
            n_vec++;
            if (div_n !== 4'(model_n) || clk_gate_en !== 1'b1) begin
                n_err++; $display("FAIL drain_entry div_n=%0d gate=%b exp %0d 1", div_n, clk_gate_en, model_n);
            end
            while (busy === 1'b1 && s <= 64) begin
                busy_c++;
                if (clk_gate_en !== 1'b1) gate_lo++;
                if (div_reset === 1'b1) rst_hi++;
                div_wrap = (s == d);
                if (inject) begin
                    req_valid = (s == 1);
                    req_n     = ~4'(n);
                end
                @(negedge clk);
                s++;
            end
            div_wrap = 1'b0; req_valid = 1'b0;
            n_vec++;
            if (busy !== 1'b0) begin
                n_err++; $display("FAIL change_timeout busy still %b after %0d cycles", busy, s);
            end
            n_vec++;
            if (busy_c != exp_drain + 1 + SETTLE) begin
                n_err++; $display("FAIL busy_len n=%0d d=%0d got %0d exp %0d", n, d, busy_c, exp_drain + 1 + SETTLE);
            end
            n_vec++;
            if (gate_lo != 1 + SETTLE || rst_hi != 1) begin
                n_err++; $display("FAIL gate_rst_len got gate_lo=%0d rst_hi=%0d exp %0d 1", gate_lo, rst_hi, 1 + SETTLE);
            end
            n_vec++;
            if (div_n !== 4'(n) || clk_gate_en !== 1'b1) begin
                n_err++; $display("FAIL new_div_n got %0d gate=%b exp %0d 1", div_n, clk_gate_en, n);
            end
            model_n = n;
        end
    endtask

    task automatic test_change();
        send_req(5, 3, 1'b0);
        send_req(6, 1, 1'b1);
    endtask

    task automatic test_illegal_and_noop();
        send_req(1, 1, 1'b0);
        send_req(0, 1, 1'b0);
        send_req(model_n, 1, 1'b0);
    endtask

    task automatic test_watchdog();
`ifdef CLK_DIV_CTRL_STATS_EN
        n_vec++;
        if (wdog_hit !== 1'b0) begin
            n_err++; $display("FAIL wdog_hit_pre got %b exp 0", wdog_hit);
        end
`endif
        send_req(9, 100, 1'b0);
`ifdef CLK_DIV_CTRL_STATS_EN
        n_vec++;
        if (wdog_hit !== 1'b1) begin
            n_err++; $display("FAIL wdog_hit_post got %b exp 1", wdog_hit);
        end
`endif
    endtask

    // Reset while settling on divisor 7; the sequence must restart at HOLD with N=3
    task automatic test_reset_mid();
        req_valid = 1'b1; req_n = 4'd7;
        @(negedge clk);
        req_valid = 1'b0; div_wrap = 1'b1;
        @(negedge clk);
        div_wrap = 1'b0;
        n_vec++;
        if (div_n !== 4'd7 || div_reset !== 1'b1) begin
            n_err++; $display("FAIL mid_hold div_n=%0d rst=%b exp 7 1", div_n, div_reset);
        end
        @(negedge clk);
        test_reset();
    endtask

    task automatic test_random();
        for (int i = 0; i < 24; i++) begin
            send_req(int'($urandom_range(0, 15)), int'($urandom_range(1, 20)), 1'($urandom_range(0, 1)));
        end
    endtask

    task automatic test_stats();
`ifdef CLK_DIV_CTRL_STATS_EN
        test_reset();
        n_vec++;
        if (change_cnt !== 16'd0 || wdog_hit !== 1'b0) begin
            n_err++; $display("FAIL stats_reset cnt=%0d hit=%b exp 0 0", change_cnt, wdog_hit);
        end
        send_req(4, 2, 1'b0);
        send_req(6, 1, 1'b0);
        send_req(1, 1, 1'b0);
        send_req(6, 1, 1'b0);
        send_req(8, 3, 1'b0);
        n_vec++;
        if (change_cnt !== 16'd3) begin
            n_err++; $display("FAIL stats_cnt3 got %0d exp 3", change_cnt);
        end
        dut.change_cnt_q = 16'hFFFE;
        send_req(10, 1, 1'b0);
        send_req(11, 1, 1'b0);
        n_vec++;
        if (change_cnt !== 16'hFFFF) begin
            n_err++; $display("FAIL stats_sat got %h exp ffff", change_cnt);
        end
`endif
    endtask

    initial begin
        reset = 1'b1; req_valid = 1'b0; req_n = 4'd0; div_wrap = 1'b0;
        test_reset();
        test_change();
        test_illegal_and_noop();
        test_watchdog();
        test_reset_mid();
        test_random();
        test_stats();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
